// File: rtl/i2c_slave_regs.sv
// I2C register-pointer target: oversampled SCL/SDA, open-drain SDA drive,
// single-port register-file interface toward on-chip registers.
module i2c_slave_regs #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AUTO_INC    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [6:0] dev_add,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wr_data,
   output logic       reg_wr,
   input  logic [7:0] reg_rd_data,
   output logic       reg_rd,
   output logic       busy,
   output logic       nack_seen
);

   localparam logic [7:0] PTR_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_MACK
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_p;
   logic                   r_sda_p;
   logic                   w_scl_s;
   logic                   w_sda_s;
   logic                   w_scl_rise;
   logic                   w_scl_fall;
   logic                   w_start;
   logic                   w_stop;

   state_t     r_state,     w_state_nxt;
   logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
   logic [7:0] r_shift,     w_shift_nxt;
   logic [7:0] r_tx,        w_tx_nxt;
   logic       r_sda_oe,    w_sda_oe_nxt;
   logic [7:0] r_reg_addr,  w_reg_addr_nxt;
   logic [7:0] r_wr_data,   w_wr_data_nxt;
   logic       r_reg_wr,    w_reg_wr_nxt;
   logic       r_reg_rd,    w_reg_rd_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_nack_seen, w_nack_seen_nxt;
   logic       r_inc_pend,  w_inc_pend_nxt;
   logic [7:0] w_byte;

   // Synchronize pad inputs; reset to the idle-high bus level so no false edge appears
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_p    <= 1'b1;
         r_sda_p    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
         r_scl_p    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_p    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl_s & ~r_scl_p;
   assign w_scl_fall = ~w_scl_s & r_scl_p;
   assign w_start    = w_scl_s & r_sda_p & ~w_sda_s;
   assign w_stop     = w_scl_s & ~r_sda_p & w_sda_s;
   assign w_byte     = {r_shift[6:0], w_sda_s};

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_tx        <= '0;
         r_sda_oe    <= 1'b0;
         r_reg_addr  <= '0;
         r_wr_data   <= '0;
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
         r_busy      <= 1'b0;
         r_nack_seen <= 1'b0;
         r_inc_pend  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_tx        <= w_tx_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_reg_addr  <= w_reg_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_reg_wr    <= w_reg_wr_nxt;
         r_reg_rd    <= w_reg_rd_nxt;
         r_busy      <= w_busy_nxt;
         r_nack_seen <= w_nack_seen_nxt;
         r_inc_pend  <= w_inc_pend_nxt;
      end
   end

   // Next-state and output logic; bus conditions override bit processing
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_tx_nxt        = r_tx;
      w_sda_oe_nxt    = r_sda_oe;
      w_reg_addr_nxt  = r_reg_addr;
      w_wr_data_nxt   = r_wr_data;
      w_reg_wr_nxt    = 1'b0;
      w_reg_rd_nxt    = 1'b0;
      w_busy_nxt      = r_busy;
      w_nack_seen_nxt = r_nack_seen;
      w_inc_pend_nxt  = 1'b0;

      // Post-write pointer step lands the cycle after the write strobe
      if (r_inc_pend) begin
         w_reg_addr_nxt = r_reg_addr + PTR_STEP;
      end

      if (w_start) begin
         w_state_nxt     = ST_ADDR;
         w_bit_cnt_nxt   = '0;
         w_sda_oe_nxt    = 1'b0;
         w_nack_seen_nxt = 1'b0;
         w_busy_nxt      = 1'b0;
      end else if (w_stop) begin
         w_state_nxt   = ST_IDLE;
         w_bit_cnt_nxt = '0;
         w_sda_oe_nxt  = 1'b0;
         w_busy_nxt    = 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: ;

            ST_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_bit_cnt == 4'd7) begin
                     w_bit_cnt_nxt = '0;
                     if ((w_byte[7:1] == dev_add) && (dev_add != '0)) begin
                        w_state_nxt = ST_ADDR_ACK;
                        w_busy_nxt  = 1'b1;
                     end else begin
                        w_state_nxt = ST_IDLE;
                     end
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end

            // ACK states: first SCL fall asserts the ACK, the second releases it.
            // r_sda_oe doubles as the phase flag because it is never set on entry.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     if (r_state == ST_ADDR_ACK) begin
                        if (r_shift[0]) begin
                           w_tx_nxt      = reg_rd_data;
                           w_reg_rd_nxt  = 1'b1;
                           w_sda_oe_nxt  = ~reg_rd_data[7];
                           w_bit_cnt_nxt = '0;
                           w_state_nxt   = ST_RD;
                        end else begin
                           w_state_nxt = ST_PTR;
                        end
                     end else begin
                        w_state_nxt = ST_WR;
                     end
                  end
               end
            end

            ST_PTR: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_bit_cnt == 4'd7) begin
                     w_bit_cnt_nxt  = '0;
                     w_reg_addr_nxt = w_byte;
                     w_state_nxt    = ST_PTR_ACK;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end

            ST_WR: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_bit_cnt == 4'd7) begin
                     w_bit_cnt_nxt  = '0;
                     w_wr_data_nxt  = w_byte;
                     w_reg_wr_nxt   = 1'b1;
                     w_inc_pend_nxt = 1'b1;
                     w_state_nxt    = ST_WR_ACK;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end

            // Bit count here counts bits already clocked out by the master
            ST_RD: begin
               if (w_scl_rise) begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_sda_oe_nxt  = 1'b0;
                     w_bit_cnt_nxt = '0;
                     w_state_nxt   = ST_RD_MACK;
                  end else begin
                     w_tx_nxt     = {r_tx[6:0], 1'b0};
                     w_sda_oe_nxt = ~r_tx[6];
                  end
               end
            end

            // Bit count 1 marks a master ACK awaiting the next SCL fall
            ST_RD_MACK: begin
               if (w_scl_rise) begin
                  w_reg_addr_nxt = r_reg_addr + PTR_STEP;
                  if (w_sda_s) begin
                     w_nack_seen_nxt = 1'b1;
                     w_state_nxt     = ST_IDLE;
                  end else begin
                     w_bit_cnt_nxt = 4'd1;
                  end
               end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                  w_tx_nxt      = reg_rd_data;
                  w_reg_rd_nxt  = 1'b1;
                  w_sda_oe_nxt  = ~reg_rd_data[7];
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = ST_RD;
               end
            end

            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign sda_oe      = r_sda_oe;
   assign reg_addr    = r_reg_addr;
   assign reg_wr_data = r_wr_data;
   assign reg_wr      = r_reg_wr;
   assign reg_rd      = r_reg_rd;
   assign busy        = r_busy;
   assign nack_seen   = r_nack_seen;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bus-level master model, register-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

   localparam int Q = 50;   // quarter SCL period in ns (SCL = 20 clk periods)

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic [6:0] dev_add0 = 7'h50;
   logic       sda_oe0, sda_oe1;
   logic [7:0] reg_addr0, reg_wr_data0, reg_rd_data0;
   logic [7:0] reg_addr1, reg_wr_data1;
   logic       reg_wr0, reg_rd0, busy0, nack_seen0;
   logic       reg_wr1, reg_rd1, busy1, nack_seen1;
   logic       sda_bus;
   logic [7:0] mem0 [256];

   int n_chk = 0;
   int n_fail = 0;
   int cnt_oe0 = 0;
   int cnt_busy0 = 0;
   logic [15:0] q_wr0 [$];
   logic [15:0] q_wr1 [$];
   logic [7:0]  q_rd0 [$];

   always #5 clk = ~clk;

   assign sda_bus      = sda_m & ~sda_oe0 & ~sda_oe1;
   assign reg_rd_data0 = mem0[reg_addr0];

   i2c_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(1)) u_dut (
      .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe0),
      .dev_add(dev_add0), .reg_addr(reg_addr0), .reg_wr_data(reg_wr_data0),
      .reg_wr(reg_wr0), .reg_rd_data(reg_rd_data0), .reg_rd(reg_rd0),
      .busy(busy0), .nack_seen(nack_seen0)
   );

   i2c_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(0)) u_dut_noinc (
      .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe1),
      .dev_add(7'h33), .reg_addr(reg_addr1), .reg_wr_data(reg_wr_data1),
      .reg_wr(reg_wr1), .reg_rd_data(8'h00), .reg_rd(reg_rd1),
      .busy(busy1), .nack_seen(nack_seen1)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard whenever a DUT presents a register strobe
   initial begin
      forever begin
         @(negedge clk);
         if (sda_oe0) cnt_oe0++;
         if (busy0) cnt_busy0++;
         if (reg_wr0) begin
            if (q_wr0.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL wr0_unexpected: got addr 0x%0h data 0x%0h, required no write", reg_addr0, reg_wr_data0);
            end else chk("wr0", {16'h0, reg_addr0, reg_wr_data0}, {16'h0, q_wr0.pop_front()});
         end
         if (reg_rd0) begin
            if (q_rd0.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rd0_unexpected: got addr 0x%0h, required no read", reg_addr0);
            end else chk("rd0_addr", {24'h0, reg_addr0}, {24'h0, q_rd0.pop_front()});
         end
         if (reg_wr1) begin
            if (q_wr1.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL wr1_unexpected: got addr 0x%0h data 0x%0h, required no write", reg_addr1, reg_wr_data1);
            end else chk("wr1", {16'h0, reg_addr1, reg_wr_data1}, {16'h0, q_wr1.pop_front()});
         end
         if (reg_rd1) begin
            n_chk++; n_fail++;
            $display("FAIL rd1_unexpected: got addr 0x%0h, required no read", reg_addr1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, required test completion");
      $fatal(1, "watchdog expired");
   end

   task automatic bus_start();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic bit_out(input logic b);
      sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic bit_in(output logic b);
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(b);
      ack = ~b;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(nack);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd;
      int         oe_snap, busy_snap;

      for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
      mem0[8'h20] = 8'h5A;
      mem0[8'h21] = 8'hC3;
      mem0[8'h30] = 8'h3C;
      mem0[8'h50] = 8'h96;

      // Reset values
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sda_oe", {31'h0, sda_oe0}, 0);
      chk("rst_reg_addr", {24'h0, reg_addr0}, 0);
      chk("rst_wr_data", {24'h0, reg_wr_data0}, 0);
      chk("rst_strobes", {30'h0, reg_wr0, reg_rd0}, 0);
      chk("rst_busy_nack", {30'h0, busy0, nack_seen0}, 0);
      @(negedge clk); reset = 1'b0;
      #(4*Q);

      // Write two bytes from pointer 0x10
      bus_start();
      send_byte(8'hA0, ack); chk("wr_ack_addr", {31'h0, ack}, 1);
      chk("wr_busy", {31'h0, busy0}, 1);
      send_byte(8'h10, ack); chk("wr_ack_ptr", {31'h0, ack}, 1);
      q_wr0.push_back({8'h10, 8'hA5});
      send_byte(8'hA5, ack); chk("wr_ack_d0", {31'h0, ack}, 1);
      q_wr0.push_back({8'h11, 8'h3C});
      send_byte(8'h3C, ack); chk("wr_ack_d1", {31'h0, ack}, 1);
      bus_stop();
      chk("wr_reg_addr", {24'h0, reg_addr0}, 32'h12);
      chk("wr_busy_after", {31'h0, busy0}, 0);

      // Read two bytes with repeated start, ACK then NACK
      bus_start();
      send_byte(8'hA0, ack); chk("rd_ack_addrw", {31'h0, ack}, 1);
      send_byte(8'h20, ack); chk("rd_ack_ptr", {31'h0, ack}, 1);
      q_rd0.push_back(8'h20);
      q_rd0.push_back(8'h21);
      bus_start();
      send_byte(8'hA1, ack); chk("rd_ack_addrr", {31'h0, ack}, 1);
      recv_byte(rd, 1'b0); chk("rd_byte0", {24'h0, rd}, 32'h5A);
      recv_byte(rd, 1'b1); chk("rd_byte1", {24'h0, rd}, 32'hC3);
      chk("rd_nack_seen", {31'h0, nack_seen0}, 1);
      chk("rd_reg_addr", {24'h0, reg_addr0}, 32'h22);
      bus_stop();
      chk("rd_busy_after", {31'h0, busy0}, 0);

      // Address mismatch: 0x51 while this target is 0x50
      oe_snap = cnt_oe0; busy_snap = cnt_busy0;
      bus_start();
      #(2*Q);
      chk("mm_nack_cleared", {31'h0, nack_seen0}, 0);
      send_byte(8'hA2, ack); chk("mm_no_ack_addr", {31'h0, ack}, 0);
      send_byte(8'h55, ack); chk("mm_no_ack_d0", {31'h0, ack}, 0);
      send_byte(8'h66, ack); chk("mm_no_ack_d1", {31'h0, ack}, 0);
      bus_stop();
      chk("mm_sda_oe_cycles", cnt_oe0 - oe_snap, 0);
      chk("mm_busy_cycles", cnt_busy0 - busy_snap, 0);

      // Pointer wrap at 0xFF
      bus_start();
      send_byte(8'hA0, ack); chk("wrap_ack_addr", {31'h0, ack}, 1);
      send_byte(8'hFF, ack);
      q_wr0.push_back({8'hFF, 8'h11});
      send_byte(8'h11, ack);
      q_wr0.push_back({8'h00, 8'h22});
      send_byte(8'h22, ack); chk("wrap_ack_d1", {31'h0, ack}, 1);
      bus_stop();
      chk("wrap_reg_addr", {24'h0, reg_addr0}, 32'h01);

      // Fixed pointer instance (address 0x33)
      bus_start();
      send_byte(8'h66, ack); chk("noinc_ack_addr", {31'h0, ack}, 1);
      send_byte(8'hFF, ack);
      q_wr1.push_back({8'hFF, 8'h11});
      send_byte(8'h11, ack);
      q_wr1.push_back({8'hFF, 8'h22});
      send_byte(8'h22, ack);
      bus_stop();
      chk("noinc_reg_addr", {24'h0, reg_addr1}, 32'hFF);

      // STOP after 4 bits of a data byte: partial byte discarded
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h40, ack);
      q_wr0.push_back({8'h40, 8'h77});
      send_byte(8'h77, ack);
      bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
      bus_stop();
      chk("abort_reg_addr", {24'h0, reg_addr0}, 32'h41);
      chk("abort_busy", {31'h0, busy0}, 0);

      // START after 3 bits of a data byte, then read from current pointer
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h50, ack);
      bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
      q_rd0.push_back(8'h50);
      bus_start();
      send_byte(8'hA1, ack); chk("rs_ack_addrr", {31'h0, ack}, 1);
      recv_byte(rd, 1'b1); chk("rs_byte", {24'h0, rd}, 32'h96);
      chk("rs_reg_addr", {24'h0, reg_addr0}, 32'h51);
      bus_stop();

      // Reset while driving a 0 in RD
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h30, ack);
      q_rd0.push_back(8'h30);
      bus_start();
      send_byte(8'hA1, ack);
      for (int i = 0; i < 20 && !sda_oe0; i++) @(negedge clk);
      chk("rst_rd_driving", {31'h0, sda_oe0}, 1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_rd_sda_oe", {31'h0, sda_oe0}, 0);
      chk("rst_rd_reg_addr", {24'h0, reg_addr0}, 0);
      chk("rst_rd_wr_data", {24'h0, reg_wr_data0}, 0);
      chk("rst_rd_flags", {28'h0, reg_wr0, reg_rd0, busy0, nack_seen0}, 0);
      @(negedge clk); reset = 1'b0;
      bus_stop();

      // Zero device address never matches the general-call byte
      dev_add0 = 7'h00;
      bus_start();
      send_byte(8'h00, ack); chk("zero_addr_no_ack", {31'h0, ack}, 0);
      bus_stop();
      dev_add0 = 7'h50;

      #(4*Q);
      chk("q_wr0_drained", q_wr0.size(), 0);
      chk("q_wr1_drained", q_wr1.size(), 0);
      chk("q_rd0_drained", q_rd0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) that answers the team's I2C master.
- Implements the same register-pointer transaction format:
  - Write: START, address+W, pointer byte, N data bytes, STOP.
  - Read: START, address+W, pointer byte, repeated START, address+R, N data bytes (master ACK on each, NACK on the last), STOP.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain. Exposes a simple register-file port toward on-chip registers.
- No clock stretching.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (minimum 2).
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer is fixed.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL rate.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  SCL pad input (slave never drives SCL).
- sda_in  input  1  SDA pad input.
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- dev_add  input  7  this target's 7-bit address; sampled at each address byte.
- reg_addr  output  8  current register pointer.
- reg_wr_data  output  8  received data byte.
- reg_wr  output  1  one-cycle write strobe.
- reg_rd_data  input  8  register contents at reg_addr; combinational from reg_addr.
- reg_rd  output  1  one-cycle strobe when reg_rd_data is latched for transmit.
- busy  output  1  high from address match until STOP, START or reset.
- nack_seen  output  1  high after a master NACK during a read; cleared at next START.

Behaviour:
- Reset: sda_oe=0, reg_addr=0x00, reg_wr_data=0x00, reg_wr=0, reg_rd=0, busy=0, nack_seen=0, state=IDLE, bit count=0. Reset mid-transfer releases SDA on the next clock.
- Sampling:
  - scl_s/sda_s are the last synchronizer stage; one extra register provides previous values.
  - SCL rise/fall are 1-cycle pulses.
- Bus conditions:
  - START = sda_s falls while scl_s is high.
  - STOP = sda_s rises while scl_s is high.
  - Both have priority over bit processing.
- START, from any state including mid-byte: state=ADDR, bit count=0, sda_oe=0, nack_seen=0. This is the repeated-start path.
- STOP, from any state: state=IDLE, sda_oe=0, busy=0. reg_addr is retained.
- Bit timing:
  - Input bits are shifted MSB first on the SCL-rise pulse.
  - sda_oe changes only on the cycle after an SCL-fall pulse, never while SCL is high.
- States:
  - IDLE: waits for START.
  - ADDR: 8 bits shifted in.
    - If bits[7:1]==dev_add and dev_add!=0: go to ADDR_ACK and set busy.
    - Otherwise: go to IDLE; SDA is never driven.
  - ADDR_ACK: drive sda_oe=1 for one SCL low-high-low period.
    - R/W=0: go to PTR.
    - R/W=1: go to RD. On the same SCL fall that releases the ACK, latch reg_rd_data into the TX shift register, pulse reg_rd, and drive the MSB.
  - PTR: 8 bits in → reg_addr=byte, then PTR_ACK (ACK driven as above).
  - PTR_ACK: go to WR.
  - WR: 8 bits in.
    - On the SCL rise of bit 0: reg_wr_data=byte, pulse reg_wr for 1 cycle at the current reg_addr.
    - Next cycle: reg_addr+=AUTO_INC. Wraps 0xFF→0x00, 8-bit.
    - Then WR_ACK (ACK driven), then back to WR. Unlimited bytes.
  - RD:
    - sda_oe = NOT(tx bit): drive low for 0, release for 1.
    - After the 8th bit's SCL fall, release SDA and go to RD_MACK.
  - RD_MACK: sample sda_s on SCL rise. In both cases reg_addr+=AUTO_INC (wrap).
    - 0 (ACK): on the next SCL fall, latch reg_rd_data at the new pointer, pulse reg_rd, go to RD.
    - 1 (NACK): set nack_seen, go to IDLE (not driving) and wait for STOP or START.
- Simultaneous events: START/STOP detected in the same cycle as an SCL edge pulse → the bus condition wins. SCL edges cannot physically coincide with a START/STOP, so any such coincidence is glitch filtering.
- A STOP or START mid-byte in WR discards the partial byte; no reg_wr is issued.
- reg_wr and reg_rd are never high in the same cycle.

Test Plan:
- Write: dev_add=0x50, master sends START, 0xA0, 0x10, 0xA5, 0x3C, STOP.
  - Required: slave ACKs all 4 bytes (sda_oe=1 in each 9th bit).
  - Required: reg_wr pulses with (0x10,0xA5) and (0x11,0x3C); reg_addr=0x12 after STOP; busy low after STOP.
- Read with repeated start: START, 0xA0, 0x20, Sr, 0xA1; registers 0x20=0x5A, 0x21=0xC3; master ACKs the first byte, NACKs the second, then STOP.
  - Required: SDA bit sequence 01011010 then 11000011.
  - Required: reg_rd pulses twice; nack_seen=1; reg_addr=0x22.
- Address mismatch: dev_add=0x50, master sends 0xA2 (address 0x51) plus 2 data bytes.
  - Required: sda_oe stays 0 throughout; no reg_wr; busy stays 0.
- Pointer wrap: write pointer 0xFF, then data 0x11, 0x22.
  - Required: writes land at 0xFF and 0x00; reg_addr=0x01.
  - With AUTO_INC=0: both writes land at 0xFF.
- Abort: STOP after 4 bits of a WR data byte, and separately reset asserted while driving a 0 in RD.
  - Required: no reg_wr on the aborted byte; sda_oe=0 within 1 clk of reset; all outputs at reset values.
- Restart mid-byte: START after 3 bits of a WR byte, followed by 0xA1.
  - Required: slave ACKs and reads from the current pointer; no spurious reg_wr.
